// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator: opcodes, FSM states
// and the decimal display limit helper.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Width of the range-check comparison; wide enough for 2W-bit results up to W=64.
  localparam int CMP_W = 128;

  function automatic logic [CMP_W-1:0] pow10(input int n);
    logic [CMP_W-1:0] v;
    v = CMP_W'(1);
    for (int i = 0; i < n && i < 38; i++) begin
      v = v * CMP_W'(10);
    end
    return v;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Request/response bundle between a calculator client and calc_seq.
interface calc_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     op;
  logic           ready;
  logic           done;
  logic [2*W-1:0] S;
  logic           neg;
  logic           err;

  modport master (
    output start, A, B, op,
    input  ready, done, S, neg, err
  );

  modport slave (
    input  start, A, B, op,
    output ready, done, S, neg, err
  );
endinterface

// File: rtl/calc_iter_unit.sv
// Bit-serial datapath shared by multiply (shift-add) and divide (restoring);
// one result bit per step, W steps per operation.
module calc_iter_unit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] result_o
);

  logic [2*W-1:0] acc_q;   // product, or quotient collected in the low W bits
  logic [2*W-1:0] opnd_q;  // multiplicand shifting left / dividend bits leaving at W-1
  logic [W-1:0]   rem_q;   // partial remainder
  logic [W-1:0]   b_q;     // multiplier shifting right / fixed divisor

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted  = {rem_q, opnd_q[W-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign result_o = acc_q;

  // NOTE: pure datapath, always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q  <= '0;
      opnd_q <= {{W{1'b0}}, a_i};
      rem_q  <= '0;
      b_q    <= b_i;
    end else if (step_i) begin
      opnd_q <= opnd_q << 1;
      if (is_div_i) begin
        // A clear borrow bit means the divisor fits into the shifted remainder.
        if (!diff[W]) begin
          rem_q <= diff[W-1:0];
          acc_q <= {acc_q[2*W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[W-1:0];
          acc_q <= {acc_q[2*W-2:0], 1'b0};
        end
      end else begin
        if (b_q[0]) acc_q <= acc_q + opnd_q;
        b_q <= b_q >> 1;
      end
    end
  end

endmodule

// File: rtl/calc_seq.sv
// Sequential add/sub/mul/div calculator with a start/ready/done handshake and a
// decimal display range check on the registered result.
module calc_seq
  import calc_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 8
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);

  localparam int               CNT_W = $clog2(W);
  localparam logic [CMP_W-1:0] MAXV  = pow10(DIGITS) - CMP_W'(1);

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_q, b_q;
  op_t            op_q;
  logic [2*W-1:0] s_q;
  logic           neg_q, err_q, done_q, ready_q;

  logic           accept;
  logic           iter_step;
  logic [2*W-1:0] iter_res;
  logic [2*W-1:0] a_ext, b_ext;
  logic [2*W-1:0] res;
  logic           res_neg, res_err;

  assign accept    = ready_q & bus.start;
  assign iter_step = (state_q == ST_EXEC) && (op_q inside {OP_MUL, OP_DIV});
  assign a_ext     = {{W{1'b0}}, a_q};
  assign b_ext     = {{W{1'b0}}, b_q};

  calc_iter_unit #(.W(W)) u_iter (
    .clk      (clk),
    .load_i   (accept),
    .step_i   (iter_step),
    .is_div_i (op_q == OP_DIV),
    .a_i      (bus.A),
    .b_i      (bus.B),
    .result_o (iter_res)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          cnt_d   = bus.op[1] ? CNT_W'(W - 1) : '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_FINISH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res     = '0;
    res_neg = 1'b0;
    case (op_q)
      OP_ADD: res = a_ext + b_ext;
      OP_SUB: begin
        if (a_q >= b_q) begin
          res = a_ext - b_ext;
        end else begin
          res     = b_ext - a_ext;
          res_neg = 1'b1;
        end
      end
      default: res = iter_res;
    endcase
    res_err = ((op_q == OP_DIV) && (b_q == '0)) || (CMP_W'(res) > MAXV);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      s_q     <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_q == ST_FINISH);
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= op_t'(bus.op);
      end
      if (state_q == ST_FINISH) begin
        if (res_err) begin
          s_q   <= '0;
          err_q <= 1'b1;
          neg_q <= 1'b0;
        end else begin
          s_q   <= res;
          err_q <= 1'b0;
          neg_q <= res_neg;
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.S     = s_q;
  assign bus.neg   = neg_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: two instances (DIGITS=8 and DIGITS=2) driven
// with directed and randomized operations, checked against an arithmetic model.
module tb_calc_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_if #(.W(W)) bus8 ();
  calc_if #(.W(W)) bus2 ();

  calc_seq #(.W(W), .DIGITS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  calc_seq #(.W(W), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int tests_run = 0;
  int fails     = 0;

  // Reference model straight from the arithmetic rules.
  function automatic void model(input int sel, input longint a, input longint b, input int op,
                                output longint s, output bit n, output bit e);
    longint r;
    longint maxv;
    maxv = (sel == 0) ? 64'd99999999 : 64'd99;
    r = 0; n = 0; e = 0;
    case (op)
      0: r = a + b;
      1: if (a >= b) r = a - b; else begin r = b - a; n = 1; end
      2: r = a * b;
      default: if (b == 0) e = 1; else r = a / b;
    endcase
    if (r > maxv) e = 1;
    if (e) begin r = 0; n = 0; end
    s = r;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] op);
    if (sel == 0) begin
      bus8.start = st; bus8.A = a; bus8.B = b; bus8.op = op;
    end else begin
      bus2.start = st; bus2.A = a; bus2.B = b; bus2.op = op;
    end
  endtask

  task automatic sample(input int sel, output logic d, output logic r,
                        output logic [2*W-1:0] s, output logic n, output logic e);
    if (sel == 0) begin
      d = bus8.done; r = bus8.ready; s = bus8.S; n = bus8.neg; e = bus8.err;
    end else begin
      d = bus2.done; r = bus2.ready; s = bus2.S; n = bus2.neg; e = bus2.err;
    end
  endtask

  // Runs one operation; lat = edges after the accepting edge until done is seen,
  // rlow = sampled cycles with ready low. With chain set, the next request is
  // presented in the done cycle; prestarted means the request is already driven.
  task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input bit scramble, input bit prestarted,
                        input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic [1:0] nop,
                        output logic [2*W-1:0] s, output logic n, output logic e,
                        output int lat, output int rlow);
    logic d, r, no, eo;
    logic [2*W-1:0] so;
    s = 'x; n = 1'bx; e = 1'bx;
    if (!prestarted) begin
      @(negedge clk);
      drive(sel, 1'b1, a, b, op);
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, a, b, op);
    sample(sel, d, r, so, no, eo);
    rlow = (r === 1'b0) ? 1 : 0;
    lat  = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      sample(sel, d, r, so, no, eo);
      if (d === 1'b1) begin
        s = so; n = no; e = eo; lat = k;
        if (r !== 1'b1) rlow = rlow + 100;
        if (chain) drive(sel, 1'b1, na, nb, nop);
        else       drive(sel, 1'b0, a, b, op);
        break;
      end
      if (r === 1'b0) rlow++;
      if (scramble) drive(sel, 1'($urandom), W'($urandom), W'($urandom), 2'($urandom));
    end
  endtask

  task automatic check_op(input string name, input int sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [1:0] op, input bit scramble,
                          input bit prestarted, input bit chain, input logic [W-1:0] na,
                          input logic [W-1:0] nb, input logic [1:0] nop);
    logic [2*W-1:0] s;
    logic n, e;
    int lat, rlow, exp_lat;
    longint es;
    bit en, ee;
    model(sel, longint'(a), longint'(b), int'(op), es, en, ee);
    exp_lat = (op < 2) ? 2 : W + 1;
    run_op(sel, a, b, op, scramble, prestarted, chain, na, nb, nop, s, n, e, lat, rlow);
    tests_run++;
    if ({s, n, e} !== {(2*W)'(es), en, ee}) begin
      fails++;
      $display("FAIL %s result: got S=%0d neg=%b err=%b, want S=%0d neg=%b err=%b",
               name, s, n, e, es, en, ee);
    end
    tests_run++;
    if (lat !== exp_lat || rlow !== exp_lat) begin
      fails++;
      $display("FAIL %s timing: got latency=%0d ready_low=%0d, want %0d/%0d",
               name, lat, rlow, exp_lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    logic d, r, n, e;
    logic [2*W-1:0] s;
    drive(0, 1'b0, '0, '0, 2'd0);
    drive(1, 1'b0, '0, '0, 2'd0);
    rst = 1'b0;
    #12;
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel, d, r, s, n, e);
      tests_run++;
      if ({r, d, s, n, e} !== {1'b1, 1'b0, {(2*W){1'b0}}, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_state[%0d]: got ready=%b done=%b S=%0d neg=%b err=%b, want 1 0 0 0 0",
                 sel, r, d, s, n, e);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_sub();
    check_op("add_200_100", 0, 8'd200, 8'd100, 2'd0, 0, 0, 0, '0, '0, 2'd0);
    check_op("sub_5_9",     0, 8'd5,   8'd9,   2'd1, 0, 0, 0, '0, '0, 2'd0);
    check_op("sub_9_9",     0, 8'd9,   8'd9,   2'd1, 0, 0, 0, '0, '0, 2'd0);
  endtask

  task automatic test_mul_div();
    logic d, r, n, e;
    logic [2*W-1:0] s;
    int extra;
    check_op("mul_255_255_scrambled", 0, 8'd255, 8'd255, 2'd2, 1, 0, 0, '0, '0, 2'd0);
    // Starts raised during EXEC must not have queued another operation.
    extra = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      sample(0, d, r, s, n, e);
      if (d !== 1'b0 || r !== 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignored_start: got %0d busy/done cycles after op, want 0", extra);
    end
    check_op("div_200_7",  0, 8'd200, 8'd7, 2'd3, 0, 0, 0, '0, '0, 2'd0);
    check_op("div_13_0",   0, 8'd13,  8'd0, 2'd3, 0, 0, 0, '0, '0, 2'd0);
    check_op("div_255_1",  0, 8'd255, 8'd1, 2'd3, 1, 0, 0, '0, '0, 2'd0);
  endtask

  task automatic test_digits2();
    check_op("d2_add_60_50", 1, 8'd60, 8'd50, 2'd0, 0, 0, 0, '0, '0, 2'd0);
    check_op("d2_mul_9_11",  1, 8'd9,  8'd11, 2'd2, 0, 0, 0, '0, '0, 2'd0);
    check_op("d2_sub_3_50",  1, 8'd3,  8'd50, 2'd1, 0, 0, 0, '0, '0, 2'd0);
    check_op("d2_mul_10_10", 1, 8'd10, 8'd10, 2'd2, 0, 0, 0, '0, '0, 2'd0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [1:0] op;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1));
      a   = W'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      op  = 2'($urandom);
      check_op($sformatf("rand%0d", i), sel, a, b, op, 1'($urandom), 0, 0, '0, '0, 2'd0);
    end
  endtask

  task automatic test_reset_mid_div();
    logic d, r, n, e;
    logic [2*W-1:0] s;
    int seen;
    check_op("pre_reset_add", 0, 8'd200, 8'd100, 2'd0, 0, 0, 0, '0, '0, 2'd0);
    @(negedge clk);
    drive(0, 1'b1, 8'd200, 8'd7, 2'd3);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'd200, 8'd7, 2'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sample(0, d, r, s, n, e);
    tests_run++;
    if ({r, d, s, n, e} !== {1'b1, 1'b0, {(2*W){1'b0}}, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_div_reset: got ready=%b done=%b S=%0d neg=%b err=%b, want 1 0 0 0 0",
               r, d, s, n, e);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      sample(0, d, r, s, n, e);
      if (d !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL discarded_op_done: got %0d done pulses after reset, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first_add",  0, 8'd17, 8'd25, 2'd0, 0, 0, 1, 8'd10, 8'd30, 2'd1);
    check_op("b2b_second_sub", 0, 8'd10, 8'd30, 2'd1, 0, 1, 1, 8'd99, 8'd3,  2'd2);
    check_op("b2b_third_mul",  0, 8'd99, 8'd3,  2'd2, 0, 1, 0, '0,    '0,    2'd0);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul_div();
    test_digits2();
    test_random();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
